// File: rtl/seg_pkg.sv
// Shared constants and helpers for the seven-segment scanner:
// hex-to-segment decode and a constant-safe ceil(log2).
package seg_pkg;

   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic int unsigned clog2(input int unsigned v);
      int unsigned r;
      r = 0;
      while ((64'd1 << r) < 64'(v)) r++;
      return r;
   endfunction

   // Returns {a,b,c,d,e,f,g}, active high.
   function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
      logic [6:0] seg;
      case (nib)
         4'h0: seg = 7'h7E;
         4'h1: seg = 7'h30;
         4'h2: seg = 7'h6D;
         4'h3: seg = 7'h79;
         4'h4: seg = 7'h33;
         4'h5: seg = 7'h5B;
         4'h6: seg = 7'h5F;
         4'h7: seg = 7'h70;
         4'h8: seg = 7'h7F;
         4'h9: seg = 7'h7B;
         4'hA: seg = 7'h77;
         4'hB: seg = 7'h1F;
         4'hC: seg = 7'h4E;
         4'hD: seg = 7'h3D;
         4'hE: seg = 7'h4F;
         default: seg = 7'h47;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/seg_scan_display_if.sv
// Panel bus: source words and keys in from the core side, digit drive out to the pins.
interface seg_scan_display_if
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 2,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_SRC    = 2
);
   localparam int unsigned PAGES = DATA_W / (4 * NUM_DIGITS);
   localparam int unsigned SEL_W = (NUM_SRC > 1) ? clog2(NUM_SRC) : 1;

   logic [NUM_SRC*DATA_W-1:0] src_data;
   logic [SEL_W-1:0]          src_sel;
   logic                      key_left;
   logic                      key_right;
   logic                      lzb_en;
   logic [NUM_DIGITS-1:0]     com;
   logic [7:0]                segs;
   logic [PAGES-1:0]          leds;

   modport master (
      output src_data, src_sel, key_left, key_right, lzb_en,
      input  com, segs, leds
   );

   modport slave (
      input  src_data, src_sel, key_left, key_right, lzb_en,
      output com, segs, leds
   );

endinterface

// File: rtl/key_debounce.sv
// Hold-time key debouncer: one-cycle press pulse once the key has been high
// for DEB_CNT-1 consecutive samples; holding never repeats.
module key_debounce
   import seg_pkg::*;
#(
   parameter int unsigned DEB_CNT = 500_000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic key_in,
   output logic press
);

   localparam int unsigned CW = clog2(DEB_CNT + 1);
   localparam logic [CW-1:0] CntMax  = CW'(DEB_CNT);
   localparam logic [CW-1:0] CntFire = CW'(DEB_CNT - 1);

   logic [CW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (!key_in) begin
         cnt_d = '0;
      end else if (cnt_q != CntMax) begin
         cnt_d = cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Saturation above CntFire is what keeps a held key from re-firing.
   assign press = (cnt_q == CntFire);

endmodule

// File: rtl/seg_scan_display.sv
// Multi-digit seven-segment scanner: pages a hex window through a selected
// source word, with optional leading-zero blanking and a page-indicator LED row.
module seg_scan_display
   import seg_pkg::*;
#(
   parameter int unsigned NUM_DIGITS = 2,
   parameter int unsigned DATA_W     = 32,
   parameter int unsigned NUM_SRC    = 2,
   parameter int unsigned SCAN_CNT   = 50_000,
   parameter int unsigned DEB_CNT    = 500_000
) (
   input logic               clk,
   input logic               rst_n,
   seg_scan_display_if.slave bus
);

   localparam int unsigned PAGES = DATA_W / (4 * NUM_DIGITS);
   localparam int unsigned PG_W  = (PAGES > 1) ? clog2(PAGES) : 1;
   localparam int unsigned SEL_W = (NUM_SRC > 1) ? clog2(NUM_SRC) : 1;
   localparam int unsigned DIG_W = (NUM_DIGITS > 1) ? clog2(NUM_DIGITS) : 1;
   localparam int unsigned SC_W  = clog2(SCAN_CNT);
   localparam int unsigned WIN_W = 4 * NUM_DIGITS;

   logic press_l, press_r;

   key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_left (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_in (bus.key_left),
      .press  (press_l)
   );

   key_debounce #(.DEB_CNT(DEB_CNT)) u_deb_right (
      .clk    (clk),
      .rst_n  (rst_n),
      .key_in (bus.key_right),
      .press  (press_r)
   );

   logic [PG_W-1:0]       page_q, page_d;
   logic [PAGES-1:0]      leds_q, leds_d;
   logic [SC_W-1:0]       cnt_q, cnt_d;
   logic [DIG_W-1:0]      digit_q, digit_d;
   logic [NUM_DIGITS-1:0] com_q, com_d;
   logic [7:0]            segs_q, segs_d;
   logic                  tick;

   always_comb begin
      page_d = page_q;
      if (PAGES > 1) begin
         if (press_l && !press_r) begin
            page_d = (page_q == PG_W'(PAGES - 1)) ? '0 : page_q + PG_W'(1);
         end else if (press_r && !press_l) begin
            page_d = (page_q == '0) ? PG_W'(PAGES - 1) : page_q - PG_W'(1);
         end
      end
      leds_d = PAGES'(1) << page_d;
   end

   always_comb begin
      tick    = (cnt_q == SC_W'(SCAN_CNT - 1));
      cnt_d   = tick ? '0 : cnt_q + SC_W'(1);
      digit_d = digit_q;
      if (tick) begin
         digit_d = (digit_q == DIG_W'(NUM_DIGITS - 1)) ? '0 : digit_q + DIG_W'(1);
      end
   end

   logic [DATA_W-1:0] word;
   logic [WIN_W-1:0]  win;
   logic [3:0]        nib;
   logic              blank;
   logic              dp;

   // Decode from the registered digit so com and segs load in lockstep.
   always_comb begin
      word = '0;
      for (int i = 0; i < NUM_SRC; i++) begin
         if (bus.src_sel == SEL_W'(i)) word = bus.src_data[i*DATA_W +: DATA_W];
      end
      win = '0;
      for (int p = 0; p < PAGES; p++) begin
         if (page_q == PG_W'(p)) win = word[p*WIN_W +: WIN_W];
      end
      nib   = '0;
      blank = bus.lzb_en && (digit_q != '0);
      for (int j = 0; j < NUM_DIGITS; j++) begin
         if (digit_q == DIG_W'(j)) nib = win[4*j +: 4];
         if ((DIG_W'(j) >= digit_q) && (win[4*j +: 4] != 4'h0)) blank = 1'b0;
      end
      dp     = (digit_q == '0) && (page_q != '0);
      segs_d = {blank ? SEG_BLANK : hex_to_seg(nib), dp};
      com_d  = NUM_DIGITS'(1) << digit_q;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         page_q  <= '0;
         leds_q  <= PAGES'(1);
         cnt_q   <= '0;
         digit_q <= '0;
         com_q   <= '0;
         segs_q  <= '0;
      end else begin
         page_q  <= page_d;
         leds_q  <= leds_d;
         cnt_q   <= cnt_d;
         digit_q <= digit_d;
         com_q   <= com_d;
         segs_q  <= segs_d;
      end
   end

   assign bus.com  = com_q;
   assign bus.segs = segs_q;
   assign bus.leds = leds_q;

endmodule
